// File: rtl/epl_column_access_ctrl_pkg.sv
// Shared constants for the EPLFFRAM02 column access controller: address width,
// state encoding, default phase timing and a small sizing helper.
package epl_column_access_ctrl_pkg;

  localparam int ADDR_AY  = 6;
  localparam int ADDR_AYO = ADDR_AY;

  localparam int BL_W_DEF    = 3;
  localparam int T_SETUP_DEF = 2;
  localparam int T_CS_DEF    = 4;
  localparam int T_GAP_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CS    = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/epl_col_phase_timer.sv
// Down-counting phase timer: load a cycle count minus one, count down to zero,
// flag the terminal cycle of the phase.
module epl_col_phase_timer #(
  parameter int PW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [PW-1:0] load_val_i,
  output logic          tc_o
);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/epl_column_access_ctrl.sv
// Column access sequencer: per column runs SETUP/CS/GAP phases, wraps the column address.
// Optional EPL_COL_ABORT_EN adds pAbort_i/pAborted_o to cut a burst short.
module epl_column_access_ctrl
  import epl_column_access_ctrl_pkg::*;
#(
  parameter int AW      = ADDR_AY,
  parameter int BL_W    = BL_W_DEF,
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_CS    = T_CS_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic            pClk_i,
  input  logic            pRst_i,
  input  logic            pReq_i,
  input  logic [AW-1:0]   pAddr_i,
  input  logic [BL_W-1:0] pBurst_i,
`ifdef EPL_COL_ABORT_EN
  input  logic            pAbort_i,
  output logic            pAborted_o,
`endif
  output logic            pAck_o,
  output logic [AW-1:0]   pAc_o,
  output logic            pCsEn_o,
  output logic            pLast_o,
  output logic            pBusy_o,
  output logic            pDone_o
);

  localparam int PW = $clog2(max3(T_SETUP, T_CS, T_GAP)) + 1;
  localparam logic [PW-1:0] LD_SETUP = PW'(T_SETUP - 1);
  localparam logic [PW-1:0] LD_CS    = PW'(T_CS - 1);
  localparam logic [PW-1:0] LD_GAP   = PW'(T_GAP - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ac_q;
  logic [BL_W-1:0] rem_q;
  logic            tmr_load, tmr_tc;
  logic [PW-1:0]   tmr_val;
  logic            ack_w, last_col, gap_end, abort_w, in_burst;

  assign in_burst = (state_q == ST_SETUP) || (state_q == ST_CS) || (state_q == ST_GAP);
  assign ack_w    = (state_q == ST_IDLE) && pReq_i;
  assign last_col = (rem_q == BL_W'(1));

`ifdef EPL_COL_ABORT_EN
  logic aborted_q;

  assign abort_w = pAbort_i && in_burst;

  always_ff @(posedge pClk_i) begin
    if (pRst_i) begin
      aborted_q <= 1'b0;
    end else if (abort_w) begin
      aborted_q <= 1'b1;
    end else if (state_q == ST_DONE) begin
      aborted_q <= 1'b0;
    end
  end

  assign pAborted_o = !pRst_i && (state_q == ST_DONE) && aborted_q;
`else
  assign abort_w = 1'b0;
`endif

  // Address and column count only move on the final GAP cycle, never inside CS.
  assign gap_end = (state_q == ST_GAP) && tmr_tc && !abort_w;

  epl_col_phase_timer #(.PW(PW)) u_timer (
    .clk_i      (pClk_i),
    .rst_i      (pRst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge pClk_i) begin
    if (pRst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pReq_i) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d  = ST_CS;
          tmr_load = 1'b1;
          tmr_val  = LD_CS;
        end
      end
      ST_CS: begin
        if (tmr_tc) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = LD_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_tc) begin
          if (last_col) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = LD_SETUP;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_w) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    pAck_o  = 1'b0;
    pCsEn_o = 1'b0;
    pLast_o = 1'b0;
    pBusy_o = 1'b0;
    pDone_o = 1'b0;
    if (!pRst_i) begin
      case (state_q)
        ST_IDLE:  pAck_o = pReq_i;
        ST_SETUP: pBusy_o = 1'b1;
        ST_CS: begin
          pBusy_o = 1'b1;
          pCsEn_o = 1'b1;
          pLast_o = last_col;
        end
        ST_GAP:   pBusy_o = 1'b1;
        ST_DONE:  pDone_o = 1'b1;
        default:  pBusy_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge pClk_i) begin
    if (pRst_i) begin
      ac_q  <= '0;
      rem_q <= '0;
    end else if (ack_w) begin
      ac_q  <= pAddr_i;
      rem_q <= (pBurst_i == '0) ? BL_W'(1) : pBurst_i;
    end else if (gap_end) begin
      ac_q  <= ac_q + AW'(1);
      rem_q <= rem_q - BL_W'(1);
    end
  end

  assign pAc_o = pRst_i ? '0 : ac_q;

endmodule

// File: tb/tb_epl_column_access_ctrl.sv
// Directed bench for epl_column_access_ctrl (AW=2, default timing): burst table
// plus hand sequences for reset mid-burst and back-to-back requests.
module tb_epl_column_access_ctrl;

  logic       clk = 1'b0;
  logic       rst, req;
  logic [1:0] addr;
  logic [2:0] burst;
  logic       ack, cs_en, last, busy, done;
  logic [1:0] ac;
`ifdef EPL_COL_ABORT_EN
  logic       abort, aborted;
`endif

  int checks   = 0;
  int failures = 0;
  logic [1:0] model_ac;

  always #5 clk = ~clk;

  epl_column_access_ctrl #(
    .AW(2), .BL_W(3), .T_SETUP(2), .T_CS(4), .T_GAP(2)
  ) dut (
    .pClk_i     (clk),
    .pRst_i     (rst),
    .pReq_i     (req),
    .pAddr_i    (addr),
    .pBurst_i   (burst),
`ifdef EPL_COL_ABORT_EN
    .pAbort_i   (abort),
    .pAborted_o (aborted),
`endif
    .pAck_o     (ack),
    .pAc_o      (ac),
    .pCsEn_o    (cs_en),
    .pLast_o    (last),
    .pBusy_o    (busy),
    .pDone_o    (done)
  );

  typedef struct {
    logic [1:0] addr;
    logic [2:0] burst;
    int         ncols;
    logic [1:0] end_ac;
  } vec_t;

  // Outputs packed as {ack, ac[1:0], cs_en, last, busy, done}.
  function automatic logic [6:0] mk(input logic a, input logic [1:0] c, input logic cs,
                                    input logic l, input logic b, input logic d);
    return {a, c, cs, l, b, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [6:0] exp);
    logic [6:0] act;
    #1;
    act = {ack, ac, cs_en, last, busy, done};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got {ack,ac,cs,last,busy,done}=%b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Caller has opened a cycle window with step(); DUT must be in IDLE.
  task automatic run_burst(input vec_t v, input string nm);
    logic [1:0] col_ac;
    logic       cs_exp;
    req = 1'b1; addr = v.addr; burst = v.burst;
    chk({nm, "_ack"}, mk(1'b1, model_ac, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int c = 0; c < v.ncols; c++) begin
      col_ac = v.addr + 2'(c);
      for (int p = 0; p < 8; p++) begin
        step();
        req = 1'b0;
        cs_exp = (p >= 2) && (p <= 5);
        chk({nm, "_col"}, mk(1'b0, col_ac, cs_exp, cs_exp && (c == v.ncols - 1), 1'b1, 1'b0));
      end
    end
    step();
    chk({nm, "_done"}, mk(1'b0, v.end_ac, 1'b0, 1'b0, 1'b0, 1'b1));
    model_ac = v.end_ac;
    step();
    chk({nm, "_idle"}, mk(1'b0, model_ac, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  vec_t tbl [4];

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{addr: 2'd0, burst: 3'd1, ncols: 1, end_ac: 2'd1};
    tbl[1] = '{addr: 2'd3, burst: 3'd3, ncols: 3, end_ac: 2'd2};
    tbl[2] = '{addr: 2'd2, burst: 3'd0, ncols: 1, end_ac: 2'd3};
    tbl[3] = '{addr: 2'd1, burst: 3'd7, ncols: 7, end_ac: 2'd0};

    rst = 1'b1; req = 1'b1; addr = 2'd3; burst = 3'd2;
`ifdef EPL_COL_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    step();
    rst = 1'b0; req = 1'b0;
    chk("reset_idle", mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    model_ac = 2'd0;

    for (int i = 0; i < 4; i++) begin
      step();
      run_burst(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset in the second CS cycle of a 3-column burst, then a request right after.
    step();
    req = 1'b1; addr = 2'd1; burst = 3'd3;
    chk("rst_mid_ack", mk(1'b1, model_ac, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int p = 0; p < 3; p++) begin
      step();
      req = 1'b0;
      chk("rst_mid_pre", mk(1'b0, 2'd1, p == 2, 1'b0, 1'b1, 1'b0));
    end
    step();
    rst = 1'b1;
    chk("rst_mid_assert", mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    chk("rst_mid_after", mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    rst = 1'b0;
    model_ac = 2'd0;
    run_burst('{addr: 2'd2, burst: 3'd1, ncols: 1, end_ac: 2'd3}, "rst_new");

    // Request held high: second ack lands on the IDLE cycle right after DONE.
    step();
    req = 1'b1; addr = 2'd1; burst = 3'd0;
    chk("hold_ack1", mk(1'b1, model_ac, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int p = 0; p < 8; p++) begin
      step();
      chk("hold_col", mk(1'b0, 2'd1, (p >= 2) && (p <= 5), (p >= 2) && (p <= 5), 1'b1, 1'b0));
    end
    step();
    chk("hold_done", mk(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
    step();
    chk("hold_ack2", mk(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int p = 0; p < 8; p++) begin
      step();
      req = 1'b0;
      chk("hold_col2", mk(1'b0, 2'd1, (p >= 2) && (p <= 5), (p >= 2) && (p <= 5), 1'b1, 1'b0));
    end
    step();
    chk("hold_done2", mk(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
    step();
    chk("hold_idle", mk(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    model_ac = 2'd2;

`ifdef EPL_COL_ABORT_EN
    // Abort in the first cycle of the second CS phase of a 4-column burst.
    step();
    req = 1'b1; addr = 2'd0; burst = 3'd4;
    chk("abort_ack", mk(1'b1, model_ac, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int p = 0; p < 11; p++) begin
      step();
      req = 1'b0;
      abort = (p == 10);
      chk("abort_run", mk(1'b0, (p < 8) ? 2'd0 : 2'd1, (p >= 2 && p <= 5) || p == 10,
                          1'b0, 1'b1, 1'b0));
    end
    step();
    abort = 1'b0;
    chk("abort_done", mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    checks++;
    if (aborted !== 1'b1) begin
      failures++;
      $display("FAIL abort_flag got %b want 1", aborted);
    end
    step();
    chk("abort_idle", mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    checks++;
    if (aborted !== 1'b0) begin
      failures++;
      $display("FAIL abort_flag_clr got %b want 0", aborted);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
